// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory port.
package riscv_mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input tie-break arbiter: fixed LS priority, or alternate against the last winner.
module rr_arb2 (
    input  logic req_if,
    input  logic req_ls,
    input  logic fixed_prio,
    input  logic rr_last,     // 1: LS won the previous grant
    output logic gnt_if,
    output logic gnt_ls
);

    always_comb begin
        gnt_if = 1'b0;
        gnt_ls = 1'b0;
        if (req_if && req_ls) begin
            if (fixed_prio || !rr_last) gnt_ls = 1'b1;
            else                        gnt_if = 1'b1;
        end else begin
            gnt_if = req_if;
            gnt_ls = req_ls;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store,
// tracking the single in-flight access and routing its response to the owner.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1,
    parameter int LS_PRIO = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [DATA_W/8-1:0] ls_be,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           owner_q, owner_d;
    owner_e           rr_last_q, rr_last_d;
    logic             we_q, we_d;

    logic done, win, arb_if, arb_ls, gnt_any;

    assign done = (state_q == ST_WAIT) && (cnt_q == CNT_W'(MEM_LAT));
    // Gating with rst keeps every output quiet while reset is held.
    assign win  = rst && ((state_q == ST_IDLE) || done);

    rr_arb2 u_arb (
        .req_if     (if_req),
        .req_ls     (ls_req),
        .fixed_prio (LS_PRIO != 0),
        .rr_last    (rr_last_q == OWN_LS),
        .gnt_if     (arb_if),
        .gnt_ls     (arb_ls)
    );

    assign if_gnt  = win && arb_if;
    assign ls_gnt  = win && arb_ls;
    assign gnt_any = if_gnt || ls_gnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            owner_q   <= OWN_IF;
            rr_last_q <= OWN_LS;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            we_q      <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        we_d      = we_q;
        if (gnt_any) begin
            // A grant in the completion cycle chains straight into the next access.
            state_d   = ST_WAIT;
            cnt_d     = CNT_W'(1);
            owner_d   = ls_gnt ? OWN_LS : OWN_IF;
            rr_last_d = ls_gnt ? OWN_LS : OWN_IF;
            we_d      = ls_gnt && ls_we;
        end else if (done) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        mem_en    = gnt_any;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ls_gnt) begin
            mem_we    = ls_we;
            mem_be    = ls_we ? ls_be : '0;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    assign if_rvalid = done && (owner_q == OWN_IF);
    assign ls_rvalid = done && (owner_q == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = (ls_rvalid && !we_q) ? mem_rdata : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter configurations sharing one clock, reset and memory model.
module tb_mem_port_arbiter;

    localparam int N = 3;  // 0: LAT1/LS prio, 1: LAT1/round-robin, 2: LAT3/LS prio

    function automatic int lat_of(input int i);
        return (i == 2) ? 3 : 1;
    endfunction
    function automatic int prio_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        if_req, if_gnt, if_rvalid, ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [N-1:0]        mem_en, mem_we, busy;
    logic [N-1:0][31:0]  if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata;
    logic [N-1:0][31:0]  mem_addr, mem_wdata, mem_rdata;
    logic [N-1:0][3:0]   ls_be, mem_be;

    logic [31:0] mem [0:255];
    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        logic [3:0][31:0] rd_pipe;

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .MEM_LAT(lat_of(g)), .LS_PRIO(prio_of(g))
        ) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_be(ls_be[g]), .ls_addr(ls_addr[g]),
            .ls_wdata(ls_wdata[g]), .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]),
            .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Read data appears lat_of(g) cycles after the command edge.
        always @(posedge clk)
            rd_pipe <= {rd_pipe[2:0], mem_en[g] ? mem[mem_addr[g][9:2]] : 32'h0};
        assign mem_rdata[g] = rd_pipe[lat_of(g)-1];
    end

    always @(posedge clk)
        if (mem_en[0] && mem_we[0])
            for (int b = 0; b < 4; b++)
                if (mem_be[0][b]) mem[mem_addr[0][9:2]][8*b +: 8] <= mem_wdata[0][8*b +: 8];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ls_req, ls_we;
        logic [3:0]  ls_be;
        logic [31:0] ls_addr, ls_wdata;
        logic        e_ig, e_lg, e_irv;
        logic [31:0] e_ird;
        logic        e_lrv;
        logic [31:0] e_lrd;
        logic        e_men, e_mwe;
        logic [3:0]  e_mbe;
        logic [31:0] e_maddr, e_mwd;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic lr, input logic lw,
        input logic [3:0] lb, input logic [31:0] la, input logic [31:0] lwd,
        input logic ig, input logic lg, input logic irv, input logic [31:0] ird,
        input logic lrv, input logic [31:0] lrd, input logic men, input logic mwe,
        input logic [3:0] mbe, input logic [31:0] ma, input logic [31:0] mwd, input logic bsy);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_be = lb;
        v.ls_addr = la; v.ls_wdata = lwd; v.e_ig = ig; v.e_lg = lg; v.e_irv = irv;
        v.e_ird = ird; v.e_lrv = lrv; v.e_lrd = lrd; v.e_men = men; v.e_mwe = mwe;
        v.e_mbe = mbe; v.e_maddr = ma; v.e_mwd = mwd; v.e_busy = bsy;
        return v;
    endfunction

    vec_t vt [0:10];
    logic [3:0] exp4 [0:6];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'h00A0_0093;
        if_req = '0; ls_req = '0; ls_we = '0; ls_be = '0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0;

        //           ir    ia     lr    lw    be    la      lwd            ig    lg    irv   ird            lrv   lrd            men   mwe   mbe   maddr   mwd            busy
        vt[0]  = mk(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h10,  32'h0,         1'b0);
        vt[1]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b1, 32'h00A00093,  1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1);
        vt[2]  = mk(1'b1, 32'h20, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF,  1'b0);
        vt[3]  = mk(1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 32'h20,  32'h0,         1'b1);
        vt[4]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 4'h0, 32'h100, 32'h0,         1'b0, 1'b1, 1'b1, 32'h10000008,  1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h100, 32'h0,         1'b1);
        vt[5]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hDEADBEEF,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1);
        vt[6]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0);
        vt[7]  = mk(1'b0, 32'h0,  1'b1, 1'b1, 4'h3, 32'h104, 32'h1234ABCD,  1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 4'h3, 32'h104, 32'h1234ABCD,  1'b0);
        vt[8]  = mk(1'b0, 32'h0,  1'b1, 1'b0, 4'hF, 32'h104, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 4'h0, 32'h104, 32'h0,         1'b1);
        vt[9]  = mk(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h1000ABCD,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b1);
        vt[10] = mk(1'b0, 32'h0,  1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,   32'h0,         1'b0);

        // {if_gnt, ls_gnt, if_rvalid, ls_rvalid} on the round-robin instance
        exp4 = '{4'b1000, 4'b0110, 4'b1001, 4'b0110, 4'b1001, 4'b0110, 4'b0001};

        // Reset held with every requester active: all outputs quiet.
        if_req = '1; ls_req = '1;
        for (int g = 0; g < N; g++) begin
            if_addr[g] = 32'h40; ls_addr[g] = 32'h80; ls_wdata[g] = 32'h55; ls_be[g] = 4'hF;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < N; g++)
            chk($sformatf("reset_out%0d", g),
                160'({if_gnt[g], ls_gnt[g], if_rvalid[g], ls_rvalid[g], if_rdata[g], ls_rdata[g],
                      mem_en[g], mem_we[g], mem_be[g], mem_addr[g], mem_wdata[g], busy[g]}), 160'(0));

        // Release: grant appears before the next edge; requests drop so nothing is accepted.
        rst = 1'b1;
        #1;
        chk("release_gnt0", 160'({if_gnt[0], ls_gnt[0]}), 160'(2'b01));
        chk("release_gnt1", 160'({if_gnt[1], ls_gnt[1]}), 160'(2'b10));
        chk("release_gnt2", 160'({if_gnt[2], ls_gnt[2]}), 160'(2'b01));
        if_req = '0; ls_req = '0;
        for (int g = 0; g < N; g++) begin
            if_addr[g] = '0; ls_addr[g] = '0; ls_wdata[g] = '0; ls_be[g] = '0;
        end

        // Table vectors on the LAT1 / LS-priority instance.
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if_req[0] = vt[k].if_req; if_addr[0] = vt[k].if_addr;
            ls_req[0] = vt[k].ls_req; ls_we[0] = vt[k].ls_we; ls_be[0] = vt[k].ls_be;
            ls_addr[0] = vt[k].ls_addr; ls_wdata[0] = vt[k].ls_wdata;
            #1;
            chk($sformatf("vec%0d", k),
                160'({if_gnt[0], ls_gnt[0], if_rvalid[0], if_rdata[0], ls_rvalid[0], ls_rdata[0],
                      mem_en[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0], busy[0]}),
                160'({vt[k].e_ig, vt[k].e_lg, vt[k].e_irv, vt[k].e_ird, vt[k].e_lrv, vt[k].e_lrd,
                      vt[k].e_men, vt[k].e_mwe, vt[k].e_mbe, vt[k].e_maddr, vt[k].e_mwd, vt[k].e_busy}));
        end

        // Round-robin: both requesting, strict alternation starting with IF.
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if_req[1] = (k < 6); if_addr[1] = 32'h10;
            ls_req[1] = (k < 6); ls_addr[1] = 32'h20; ls_we[1] = 1'b0;
            #1;
            chk($sformatf("rr%0d", k), 160'({if_gnt[1], ls_gnt[1], if_rvalid[1], ls_rvalid[1]}),
                160'(exp4[k]));
        end
        @(negedge clk);
        ls_req[1] = 1'b0; if_req[1] = 1'b0;

        // LAT3: continuous IF requests, grant every third cycle.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if_req[2] = 1'b1; if_addr[2] = 32'h10;
            #1;
            chk($sformatf("lat3_%0d", k),
                160'({if_gnt[2], if_rvalid[2], busy[2], if_rdata[2]}),
                160'({(k % 3 == 0), (k > 0 && k % 3 == 0), (k > 0),
                      (k > 0 && k % 3 == 0) ? 32'h00A00093 : 32'h0}));
        end
        @(negedge clk);
        if_req[2] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("lat3_drain", 160'({busy[2], if_rvalid[2]}), 160'(0));

        // Reset during an LS read: the response is discarded.
        @(negedge clk);
        ls_req[2] = 1'b1; ls_we[2] = 1'b0; ls_addr[2] = 32'h100;
        #1;
        chk("rst_mid_gnt", 160'(ls_gnt[2]), 160'(1));
        @(negedge clk);
        ls_req[2] = 1'b0; ls_addr[2] = '0;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 160'(busy[2]), 160'(0));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rst_mid_quiet%0d", k), 160'({ls_rvalid[2], busy[2]}), 160'(0));
            @(negedge clk);
        end
        if_req[2] = 1'b1; if_addr[2] = 32'h20;
        #1;
        chk("post_rst_gnt", 160'(if_gnt[2]), 160'(1));
        @(negedge clk);
        if_req[2] = 1'b0; if_addr[2] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_rd", 160'({if_rvalid[2], if_rdata[2], ls_rvalid[2]}),
            160'({1'b1, 32'h10000008, 1'b0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
